// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/stage-control bundle between the pipeline core and pipe_hazard_ctrl.
// The core side (master) raises hazard requests; the sequencer side (slave) returns enables/clears.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             lu_req;
    logic             jb;
    logic             halt_req;
    logic             resume;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_clr;
    logic             id_ex_en;
    logic             id_ex_clr;
    logic             ex_mem_en;
    logic             ex_mem_clr;
    logic             mem_wb_en;
    logic             mem_wb_clr;
    logic [1:0]       state;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Level signals only, no valid/ready pairing: every control is meaningful every cycle.
    modport master (
        output lu_req, jb, halt_req, resume, mem_busy,
        input  pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
        input  ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr,
        input  state, halted, fault, cyc_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  lu_req, jb, halt_req, resume, mem_busy,
        output pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
        output ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr,
        output state, halted, fault, cyc_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Prioritised pipeline sequencer: halt > mem wait > jump/branch flush > load-use bubble.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  ctl
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_resume_q;
    logic              r_halt_mask;

    logic w_halt_eff;
    logic w_resume_rise;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_if_id_clr;
    logic w_id_ex_en;
    logic w_id_ex_clr;
    logic w_ex_mem_en;
    logic w_ex_mem_clr;
    logic w_mem_wb_en;
    logic w_mem_wb_clr;

    // halt_mask lets the syscall that caused the halt retire on the first cycle after resume.
    assign w_halt_eff    = ctl.halt_req & ~r_halt_mask;
    assign w_resume_rise = ctl.resume & ~r_resume_q;

    always_comb begin
        w_pc_en      = 1'b0;
        w_if_id_en   = 1'b0;
        w_if_id_clr  = 1'b0;
        w_id_ex_en   = 1'b0;
        w_id_ex_clr  = 1'b0;
        w_ex_mem_en  = 1'b0;
        w_ex_mem_clr = 1'b0;
        w_mem_wb_en  = 1'b0;
        w_mem_wb_clr = 1'b0;
        if (!rst_n) begin
            w_if_id_clr  = 1'b1;
            w_id_ex_clr  = 1'b1;
            w_ex_mem_clr = 1'b1;
            w_mem_wb_clr = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (w_halt_eff || ctl.mem_busy) begin
                w_pc_en = 1'b0;
            end else if (ctl.jb) begin
                w_pc_en     = 1'b1;
                w_if_id_en  = 1'b1;
                w_if_id_clr = 1'b1;
                w_id_ex_en  = 1'b1;
                w_id_ex_clr = 1'b1;
                w_ex_mem_en = 1'b1;
                w_mem_wb_en = 1'b1;
            end else if (ctl.lu_req) begin
                // Hold PC and IF_ID, inject a bubble into ID_EX, let the back end drain.
                w_id_ex_en  = 1'b1;
                w_id_ex_clr = 1'b1;
                w_ex_mem_en = 1'b1;
                w_mem_wb_en = 1'b1;
            end else begin
                w_pc_en     = 1'b1;
                w_if_id_en  = 1'b1;
                w_id_ex_en  = 1'b1;
                w_ex_mem_en = 1'b1;
                w_mem_wb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_resume_q  <= 1'b0;
            r_halt_mask <= 1'b0;
        end else begin
            r_resume_q <= ctl.resume;
            case (r_state)
                ST_RUN: begin
                    r_halt_mask <= 1'b0;
                    if (w_halt_eff) begin
                        r_state <= ST_HALTED;
                    end else if (ctl.mem_busy) begin
                        r_wait_cnt <= WAIT_W'(1);
                        r_state    <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!ctl.mem_busy) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_RUN;
                    end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        r_state <= ST_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (w_resume_rise) begin
                        r_state     <= ST_RUN;
                        r_halt_mask <= 1'b1;
                    end
                end
                default: r_state <= ST_FAULT;
            endcase
        end
    end

    assign ctl.pc_en      = w_pc_en;
    assign ctl.if_id_en   = w_if_id_en;
    assign ctl.if_id_clr  = w_if_id_clr;
    assign ctl.id_ex_en   = w_id_ex_en;
    assign ctl.id_ex_clr  = w_id_ex_clr;
    assign ctl.ex_mem_en  = w_ex_mem_en;
    assign ctl.ex_mem_clr = w_ex_mem_clr;
    assign ctl.mem_wb_en  = w_mem_wb_en;
    assign ctl.mem_wb_clr = w_mem_wb_clr;
    assign ctl.state      = r_state;
    assign ctl.halted     = rst_n && (r_state == ST_HALTED);
    assign ctl.fault      = rst_n && (r_state == ST_FAULT);

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall;
    logic             w_flush;

    assign w_stall = !w_pc_en && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));
    assign w_flush = (r_state == ST_RUN) && !w_halt_eff && !ctl.mem_busy && ctl.jb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign ctl.cyc_cnt   = r_cyc_cnt;
    assign ctl.stall_cnt = r_stall_cnt;
    assign ctl.flush_cnt = r_flush_cnt;
`else
    assign ctl.cyc_cnt   = '0;
    assign ctl.stall_cnt = '0;
    assign ctl.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 16;

    localparam int S_RUN   = 0;
    localparam int S_WAIT  = 1;
    localparam int S_HALT  = 2;
    localparam int S_FAULT = 3;

    // Control vector order: pc_en, if_id_en/clr, id_ex_en/clr, ex_mem_en/clr, mem_wb_en/clr
    localparam logic [8:0] CTRL_RESET  = 9'b0_01_01_01_01;
    localparam logic [8:0] CTRL_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] CTRL_FLOW   = 9'b1_10_10_10_10;
    localparam logic [8:0] CTRL_JUMP   = 9'b1_11_11_10_10;
    localparam logic [8:0] CTRL_BUBBLE = 9'b0_00_11_10_10;

    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pipeline mode plus the few facts the rules depend on.
    int               m_state       = S_RUN;
    int               m_busy_run    = 0;
    bit               m_prev_resume = 1'b0;
    bit               m_just_resumed = 1'b0;
    logic [CNT_W-1:0] m_cyc   = '0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic lu, input logic j, input logic h,
                        input logic r, input logic b);
        logic [8:0] exp_ctrl;
        logic [8:0] obs_ctrl;
        bit halt_live;
        bit took_jump;
        @(negedge clk);
        rst_n        = rst;
        bus.lu_req   = lu;
        bus.jb       = j;
        bus.halt_req = h;
        bus.resume   = r;
        bus.mem_busy = b;
        #1;
        halt_live = h && !m_just_resumed;
        took_jump = 1'b0;
        if (!rst) begin
            exp_ctrl = CTRL_RESET;
        end else if (m_state == S_RUN) begin
            if (halt_live || b) exp_ctrl = CTRL_FREEZE;
            else if (j) begin
                exp_ctrl  = CTRL_JUMP;
                took_jump = 1'b1;
            end else if (lu) exp_ctrl = CTRL_BUBBLE;
            else exp_ctrl = CTRL_FLOW;
        end else begin
            exp_ctrl = CTRL_FREEZE;
        end
        obs_ctrl = {bus.pc_en, bus.if_id_en, bus.if_id_clr, bus.id_ex_en, bus.id_ex_clr,
                    bus.ex_mem_en, bus.ex_mem_clr, bus.mem_wb_en, bus.mem_wb_clr};
        check("ctrl",   64'(obs_ctrl), 64'(exp_ctrl));
        check("state",  64'(bus.state), 64'(m_state));
        check("halted", 64'(bus.halted), 64'(rst && m_state == S_HALT));
        check("fault",  64'(bus.fault), 64'(rst && m_state == S_FAULT));
`ifdef PIPE_PERF_EN
        check("cyc_cnt",   64'(bus.cyc_cnt),   64'(m_cyc));
        check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(bus.flush_cnt), 64'(m_flush));
`else
        check("cyc_cnt",   64'(bus.cyc_cnt),   64'(0));
        check("stall_cnt", 64'(bus.stall_cnt), 64'(0));
        check("flush_cnt", 64'(bus.flush_cnt), 64'(0));
`endif
        @(posedge clk);
        if (!rst) begin
            m_state = S_RUN; m_busy_run = 0; m_prev_resume = 1'b0; m_just_resumed = 1'b0;
            m_cyc = '0; m_stall = '0; m_flush = '0;
        end else begin
            m_cyc = m_cyc + 1'b1;
            if (!exp_ctrl[8] && (m_state == S_RUN || m_state == S_WAIT)) m_stall = m_stall + 1'b1;
            if (took_jump) m_flush = m_flush + 1'b1;
            case (m_state)
                S_RUN: begin
                    m_just_resumed = 1'b0;
                    if (halt_live) m_state = S_HALT;
                    else if (b) begin
                        m_busy_run = 1;
                        m_state    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!b) begin
                        m_busy_run = 0;
                        m_state    = S_RUN;
                    end else begin
                        m_busy_run++;
                        if (m_busy_run == MEM_TIMEOUT) m_state = S_FAULT;
                    end
                end
                S_HALT: begin
                    if (r && !m_prev_resume) begin
                        m_state        = S_RUN;
                        m_just_resumed = 1'b1;
                    end
                end
                default: ;
            endcase
            m_prev_resume = r;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.lu_req   = 1'b0;
        bus.jb       = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
        bus.mem_busy = 1'b0;

        // Reset held, then idle flow
        repeat (2) step(0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Single load-use bubble
        step(1, 1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);

        // Jump with a simultaneous load-use: flush wins
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Short memory wait, hazards during wait are ignored
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Memory timeout to FAULT, sticky until reset
        repeat (20) step(1, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 1, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);

        // Halt with held resume: one restart, masked first RUN cycle, then halted again
        repeat (10) step(1, 0, 0, 1, 0, 0);
        repeat (5) step(1, 0, 0, 1, 1, 0);
        repeat (3) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);

        // Randomized segments alternating light and heavy memory traffic
        for (int seg = 0; seg < 16; seg++) begin
            int busy_pct;
            busy_pct = (seg % 2 == 0) ? 20 : 95;
            if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                step(($urandom_range(0, 99) != 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 11) == 0),
                     ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 99) < busy_pct));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
